mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the shared byte-addressable main memory in the single-memory RISC-V core. Accepts instruction-fetch reads and data loads/stores through per-port req/ack handshakes, grants the memory by round-robin, drives the memory's write-enable, byte-mode, address and write-data for one cycle per access, and returns registered read data with a completion pulse to the winning port. It sits between the core's fetch/LSU stages and the memory instance.

## Interface
- AWIDTH, 32, address width (byte address)
- DPORT, 32, data width of all data buses
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request (word read), held until i_ack
- i_addr  in  AWIDTH  fetch byte address
- i_ack  out  1  fetch request accepted this cycle
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DPORT  fetched word
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_byte  in  1  1 = byte access (bits 7:0), 0 = word
- d_addr  in  AWIDTH  data byte address
- d_wdata  in  DPORT  store data
- d_ack  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle completion pulse (loads and stores)
- d_rdata  out  DPORT  load data (byte loads zero-extended by memory); 0 for stores
- d_err  out  1  qualifies d_rvalid: access rejected
- mem_wr  out  1  memory write enable
- mem_byte  out  1  memory byte mode
- mem_addr  out  AWIDTH  memory address
- mem_wdata  out  DPORT  memory write data
- mem_rdata  in  DPORT  memory combinational read data

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. Reset state IDLE.
- Every cycle, arbitration runs over i_req/d_req; a winner gets ack high for that cycle and its request fields are latched. Next state = SERVE_I/SERVE_D per winner, else IDLE. Arbitration runs in SERVE states too (back-to-back accesses, one per cycle).
- Round-robin: single request wins; on both, the port not granted last wins. last_grant resets to D, so fetch wins the first tie.
- In SERVE_x: mem_* driven from latched fields; mem_wr = latched we (fetch: 0); mem_byte = latched byte (fetch: 0). In IDLE all mem_* outputs 0.
- End of SERVE_x: mem_rdata captured into x_rdata (stores capture 0); x_rvalid pulses next cycle.
- Ack never asserted without matching req; req dropped without ack is legal and discarded.

## Timing
- Accept at edge N (ack high in cycle N-1 → sampled at N); memory access cycle N; write commits at edge N+1; rvalid/rdata valid cycle N+1. Load-to-data latency 2 cycles from ack.
- Reset values: all outputs 0, state IDLE, last_grant = D.
- Reset asserted mid-access: mem_wr drops asynchronously; store not committed unless edge already passed; pending rvalid lost.
- rdata holds last value between pulses; no backpressure on responses.

## Configuration
- MEM_ARBITER_ALIGN_CHECK_EN defined: data word access with d_addr[1:0] != 0 is acked but not issued (mem_wr 0, mem_* 0 that cycle); completion has d_rvalid=1, d_err=1, d_rdata=0. Fetch with i_addr[1:0] != 0 likewise suppressed, i_rdata=0.
- Undefined: d_err tied 0; misaligned word accesses issued unchanged.

## Structure
- Package mem_arbiter_pkg: state enum (IDLE, SERVE_I, SERVE_D), port-id constants PORT_I/PORT_D.
- Sub-module mem_arbiter_rr: 2-way round-robin picker (req vector, last_grant in; one-hot grant out), combinational.

## Test plan
- Fetch only, i_addr=0x100, memory word 0xDEADBEEF → i_ack, mem_addr=0x100 next cycle, i_rvalid with i_rdata=0xDEADBEEF two cycles after ack.
- Byte store d_addr=0x203, d_wdata=0x55, then byte load 0x203 → mem_wr=1 mem_byte=1 once; load returns d_rdata=0x00000055.
- Both req held 4 cycles after reset → grants I, D, I, D; one access per cycle, no idle gaps.
- Word store 0x12345678 at 0x40, reset pulsed during SERVE_D before edge → word at 0x40 unchanged, all outputs 0.
- With MEM_ARBITER_ALIGN_CHECK_EN, word store at 0x41 → mem_wr never asserted, d_rvalid=1 d_err=1; without macro, store issued, d_err=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: sequencer states and port ids.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   // Port ids double as bit positions in the request/grant vectors.
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker. A lone request always wins; on a tie the
// port that was not granted most recently wins. Purely combinational.
module mem_arbiter_rr
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // Pick at most one winner, alternating on ties.
   always_comb begin
      grant = 2'b00;
      if (req[PORT_I] && req[PORT_D]) begin
         if (last_grant == PORT_D) grant[PORT_I] = 1'b1;
         else                      grant[PORT_D] = 1'b1;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sequencer for the single shared byte memory.
// One access per cycle: a request acked in cycle N-1 drives the memory in
// cycle N and returns registered read data with a pulse in cycle N+1.
// Optional feature: define MEM_ARBITER_ALIGN_CHECK_EN to suppress misaligned
// word accesses and flag them on d_err.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DPORT  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [AWIDTH-1:0] i_addr,
   output logic              i_ack,
   output logic              i_rvalid,
   output logic [DPORT-1:0]  i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_byte,
   input  logic [AWIDTH-1:0] d_addr,
   input  logic [DPORT-1:0]  d_wdata,
   output logic              d_ack,
   output logic              d_rvalid,
   output logic [DPORT-1:0]  d_rdata,
   output logic              d_err,
   output logic              mem_wr,
   output logic              mem_byte,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DPORT-1:0]  mem_wdata,
   input  logic [DPORT-1:0]  mem_rdata
);

   state_t            state, state_nxt;
   logic              last_grant;
   logic [1:0]        grant;
   logic              mis_c;

   logic              we_p0;
   logic              byte_p0;
   logic              sup_p0;
   logic [AWIDTH-1:0] addr_p0;
   logic [DPORT-1:0]  wdata_p0;

   logic              i_vld_p1;
   logic              d_vld_p1;
   logic [DPORT-1:0]  i_rdata_p1;
   logic [DPORT-1:0]  d_rdata_p1;

   mem_arbiter_rr u_rr (
      .req        ({d_req, i_req}),
      .last_grant (last_grant),
      .grant      (grant)
   );

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
   assign mis_c = (grant[PORT_I] && (i_addr[1:0] != 2'b00)) ||
                  (grant[PORT_D] && !d_byte && (d_addr[1:0] != 2'b00));
`else
   assign mis_c = 1'b0;
`endif

   // ---- stage p0: accept winner, latch its request ----

   // State, fairness pointer and suppression flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= PORT_D;
         sup_p0     <= 1'b0;
      end else begin
         state  <= state_nxt;
         sup_p0 <= mis_c;
         if (grant != 2'b00) last_grant <= grant[PORT_D] ? PORT_D : PORT_I;
      end
   end

   // Request fields are only consumed while in a SERVE state, so no reset.
   always_ff @(posedge clk) begin
      if (grant[PORT_I]) begin
         we_p0    <= 1'b0;
         byte_p0  <= 1'b0;
         addr_p0  <= i_addr;
         wdata_p0 <= '0;
      end else if (grant[PORT_D]) begin
         we_p0    <= d_we;
         byte_p0  <= d_byte;
         addr_p0  <= d_addr;
         wdata_p0 <= d_wdata;
      end
   end

   // Next state follows the arbitration winner; no winner means IDLE.
   always_comb begin
      state_nxt = IDLE;
      if (grant[PORT_I])      state_nxt = SERVE_I;
      else if (grant[PORT_D]) state_nxt = SERVE_D;
   end

   // Acks straight from the picker; memory bus driven only in SERVE states.
   always_comb begin
      i_ack     = grant[PORT_I];
      d_ack     = grant[PORT_D];
      mem_wr    = 1'b0;
      mem_byte  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if ((state != IDLE) && !sup_p0) begin
         mem_wr    = we_p0;
         mem_byte  = byte_p0;
         mem_addr  = addr_p0;
         mem_wdata = wdata_p0;
      end
   end

   // ---- stage p1: capture memory read data, pulse completion ----

   // Response registers; rdata holds between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_vld_p1   <= 1'b0;
         d_vld_p1   <= 1'b0;
         i_rdata_p1 <= '0;
         d_rdata_p1 <= '0;
      end else begin
         i_vld_p1 <= (state == SERVE_I);
         d_vld_p1 <= (state == SERVE_D);
         if (state == SERVE_I) i_rdata_p1 <= sup_p0 ? '0 : mem_rdata;
         if (state == SERVE_D) d_rdata_p1 <= (we_p0 || sup_p0) ? '0 : mem_rdata;
      end
   end

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
   logic d_err_p1;

   // Error flag accompanies the data completion of a suppressed access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_err_p1 <= 1'b0;
      else        d_err_p1 <= (state == SERVE_D) && sup_p0;
   end

   assign d_err = d_err_p1;
`else
   assign d_err = 1'b0;
`endif

   assign i_rvalid = i_vld_p1;
   assign i_rdata  = i_rdata_p1;
   assign d_rvalid = d_vld_p1;
   assign d_rdata  = d_rdata_p1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model with its own copy of memory.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0, d_we = 1'b0, d_byte = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic        d_ack, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        mem_wr, mem_byte;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AWIDTH(32), .DPORT(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_wr(mem_wr), .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Memory instance: combinational read, write at the clock edge.
   logic [7:0] mem [1024];
   logic [9:0] env_a;
   assign env_a = mem_addr[9:0];

   always_comb begin
      if (mem_byte) mem_rdata = {24'h0, mem[env_a]};
      else          mem_rdata = {mem[env_a + 10'd3], mem[env_a + 10'd2], mem[env_a + 10'd1], mem[env_a]};
   end

   always @(posedge clk) begin
      if (mem_wr) begin
         mem[env_a] <= mem_wdata[7:0];
         if (!mem_byte) begin
            mem[env_a + 10'd1] <= mem_wdata[15:8];
            mem[env_a + 10'd2] <= mem_wdata[23:16];
            mem[env_a + 10'd3] <= mem_wdata[31:24];
         end
      end
   end

   // Reference model state.
   logic [7:0]  ref_mem [1024];
   bit          cur_v;
   int          cur_port;
   logic        cur_we, cur_byte, cur_sup;
   logic [31:0] cur_addr, cur_wdata;
   bit          rsp_iv, rsp_dv, rsp_derr;
   logic [31:0] hold_i, hold_d;
   int          m_last;
   int          last_win;
   logic        obs_iack, obs_dack;

   function automatic logic [31:0] ref_rd(input logic [31:0] addr, input logic byt);
      logic [9:0] a;
      a = addr[9:0];
      if (byt) return {24'h0, ref_mem[a]};
      return {ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]};
   endfunction

   task automatic ref_wr(input logic [31:0] addr, input logic byt, input logic [31:0] data);
      logic [9:0] a;
      a = addr[9:0];
      ref_mem[a] = data[7:0];
      if (!byt) begin
         ref_mem[a + 10'd1] = data[15:8];
         ref_mem[a + 10'd2] = data[23:16];
         ref_mem[a + 10'd3] = data[31:24];
      end
   endtask

   task automatic model_reset();
      cur_v    = 1'b0;
      rsp_iv   = 1'b0;
      rsp_dv   = 1'b0;
      rsp_derr = 1'b0;
      hold_i   = '0;
      hold_d   = '0;
      m_last   = 1;
      last_win = -1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check everything at the falling edge, then advance the model.
   task automatic cycle();
      int          win;
      logic        e_wr, e_byte;
      logic [31:0] e_addr, e_wdata;
      @(negedge clk);
      win = -1;
      if (i_req && d_req) win = (m_last == 1) ? 0 : 1;
      else if (i_req)     win = 0;
      else if (d_req)     win = 1;
      obs_iack = i_ack;
      obs_dack = d_ack;
      chk("i_ack", 32'(i_ack), 32'(win == 0));
      chk("d_ack", 32'(d_ack), 32'(win == 1));
      e_wr = 1'b0; e_byte = 1'b0; e_addr = '0; e_wdata = '0;
      if (cur_v && !cur_sup) begin
         e_wr = cur_we; e_byte = cur_byte; e_addr = cur_addr; e_wdata = cur_wdata;
      end
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("mem_byte", 32'(mem_byte), 32'(e_byte));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("i_rvalid", 32'(i_rvalid), 32'(rsp_iv));
      chk("i_rdata", i_rdata, hold_i);
      chk("d_rvalid", 32'(d_rvalid), 32'(rsp_dv));
      chk("d_rdata", d_rdata, hold_d);
      chk("d_err", 32'(d_err), 32'(rsp_dv && rsp_derr));
      rsp_iv = 1'b0; rsp_dv = 1'b0; rsp_derr = 1'b0;
      if (cur_v) begin
         if (cur_port == 0) begin
            rsp_iv = 1'b1;
            hold_i = cur_sup ? 32'h0 : ref_rd(cur_addr, 1'b0);
         end else begin
            rsp_dv   = 1'b1;
            rsp_derr = cur_sup;
            hold_d   = (cur_we || cur_sup) ? 32'h0 : ref_rd(cur_addr, cur_byte);
            if (cur_we && !cur_sup) ref_wr(cur_addr, cur_byte, cur_wdata);
         end
      end
      cur_v = (win >= 0);
      if (win == 0) begin
         cur_port = 0; cur_we = 1'b0; cur_byte = 1'b0;
         cur_addr = i_addr; cur_wdata = '0;
         cur_sup  = ALIGN && (i_addr[1:0] != 2'b00);
      end else if (win == 1) begin
         cur_port = 1; cur_we = d_we; cur_byte = d_byte;
         cur_addr = d_addr; cur_wdata = d_wdata;
         cur_sup  = ALIGN && !d_byte && (d_addr[1:0] != 2'b00);
      end
      if (win >= 0) m_last = win;
      last_win = win;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr(input bit word);
      logic [31:0] a;
      a = 32'($urandom_range(0, 1023));
      if (word && ($urandom_range(0, 9) != 0)) a[1:0] = 2'b00;
      return a;
   endfunction

   initial begin
      logic [31:0] pre;
      logic [31:0] dv;
      for (int k = 0; k < 1024; k++) begin
         dv = $urandom;
         mem[k] <= dv[7:0];
         ref_mem[k] = dv[7:0];
      end
      dv = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
         mem[256 + k] <= dv[8*k +: 8];
         ref_mem[256 + k] = dv[8*k +: 8];
      end
      model_reset();

      // Reset state: every output low.
      #2;
      cycle();
      cycle();
      rst_n = 1'b1;

      // Fetch of 0xDEADBEEF at 0x100.
      i_req = 1'b1; i_addr = 32'h100;
      cycle();
      i_req = 1'b0;
      #1;
      chk("fetch_mem_addr", mem_addr, 32'h100);
      cycle();
      chk("fetch_rvalid", 32'(i_rvalid), 32'd1);
      chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
      cycle();

      // Byte store 0x55 at 0x203, then byte load back.
      d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 32'h203; d_wdata = 32'h55;
      cycle();
      d_req = 1'b0;
      #1;
      chk("bst_mem_wr", 32'(mem_wr), 32'd1);
      chk("bst_mem_byte", 32'(mem_byte), 32'd1);
      cycle();
      cycle();
      d_req = 1'b1; d_we = 1'b0; d_byte = 1'b1; d_addr = 32'h203;
      cycle();
      d_req = 1'b0;
      cycle();
      chk("bld_rvalid", 32'(d_rvalid), 32'd1);
      chk("bld_rdata", d_rdata, 32'h00000055);
      cycle();

      // Both ports held after a fresh reset: I, D, I, D.
      rst_n = 1'b0;
      model_reset();
      cycle();
      rst_n = 1'b1;
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h104;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("tie_i_ack", 32'(obs_iack), 32'(k % 2 == 0));
         chk("tie_d_ack", 32'(obs_dack), 32'(k % 2 == 1));
      end
      i_req = 1'b0; d_req = 1'b0;
      cycle();
      cycle();

      // Word store interrupted by reset before its commit edge.
      pre = ref_rd(32'h40, 1'b0);
      d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 32'h40; d_wdata = 32'h12345678;
      cycle();
      d_req = 1'b0;
      #1;
      chk("rst_pre_mem_wr", 32'(mem_wr), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_i_rdata", i_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_word_kept", {mem[67], mem[66], mem[65], mem[64]}, pre);
      cycle();
      rst_n = 1'b1;

      // Misaligned word store at 0x41.
      d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 32'h41; d_wdata = 32'hA5A5A5A5;
      cycle();
      d_req = 1'b0;
      #1;
      chk("mis_mem_wr", 32'(mem_wr), 32'(!ALIGN));
      cycle();
      chk("mis_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("mis_d_err", 32'(d_err), 32'(ALIGN));
      cycle();

      // Random traffic from both ports.
      for (int n = 0; n < 400; n++) begin
         if (i_req && (last_win == 0))                 i_req = 1'b0;
         else if (i_req && ($urandom_range(0, 19) == 0)) i_req = 1'b0;
         if (d_req && (last_win == 1))                 d_req = 1'b0;
         else if (d_req && ($urandom_range(0, 19) == 0)) d_req = 1'b0;
         if (!i_req && ($urandom_range(0, 99) < 55)) begin
            i_req  = 1'b1;
            i_addr = rand_addr(1'b1);
         end
         if (!d_req && ($urandom_range(0, 99) < 55)) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_byte  = 1'($urandom_range(0, 1));
            d_addr  = rand_addr(!d_byte);
            d_wdata = $urandom;
         end
         cycle();
      end
      i_req = 1'b0; d_req = 1'b0;
      for (int n = 0; n < 3; n++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
